// File: rtl/interp_sample_ctrl_if.sv
// Handshake bundle for the sample-index controller: control, adder loop and downstream
// sample channel. slave is the controller's view, master is the environment's view.
interface interp_sample_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] step;
    logic             abort;
    logic [CNT_W-1:0] add_a;
    logic [CNT_W-1:0] add_b;
    logic [CNT_W-1:0] add_c;
    logic [CNT_W-1:0] smp_idx;
    logic             smp_vld;
    logic             smp_rdy;
    logic             last;
    logic             busy;
    logic             done;

    modport slave (
        input  start, step, abort, add_c, smp_rdy,
        output add_a, add_b, smp_idx, smp_vld, last, busy, done
    );

    modport master (
        output start, step, abort, add_c, smp_rdy,
        input  add_a, add_b, smp_idx, smp_vld, last, busy, done
    );
endinterface

// File: rtl/interp_sample_ctrl.sv
// Sample-index controller: walks an index from 0 by a latched stride using an external
// adder, offering one index per handshake and pulsing done after the final one.
module interp_sample_ctrl #(
    parameter int CNT_W     = 4,
    parameter int N_SAMPLES = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    interp_sample_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Block limit held one bit wider than the index so that N_SAMPLES = 2**CNT_W fits.
    localparam logic [CNT_W:0]   N_LIM    = (CNT_W + 1)'(N_SAMPLES);
    localparam logic [CNT_W-1:0] IDX_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] STEP_ONE = CNT_W'(1);

    // A zero stride would never advance, so it is promoted to one.
    function automatic logic [CNT_W-1:0] norm_step(input logic [CNT_W-1:0] raw);
        if (raw == IDX_ZERO) begin
            return STEP_ONE;
        end else begin
            return raw;
        end
    endfunction

    // Final-index test on the unwrapped sum, independent of the adder's modulo result.
    function automatic logic is_final(input logic [CNT_W-1:0] idx,
                                      input logic [CNT_W-1:0] stride);
        logic [CNT_W:0] sum;
        sum = {1'b0, idx} + {1'b0, stride};
        return (sum >= N_LIM);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] idx_r;
    logic [CNT_W-1:0] idx_nxt_s;
    logic [CNT_W-1:0] step_r;
    logic [CNT_W-1:0] step_nxt_s;
    logic             vld_s;
    logic             last_s;
    logic             hs_s;

    assign vld_s  = (state_r == RUN);
    assign last_s = vld_s && is_final(idx_r, step_r);
    assign hs_s   = vld_s && bus.smp_rdy;

    // State, index and stride registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
            step_r  <= STEP_ONE;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            step_r  <= step_nxt_s;
        end
    end

    // Next-state logic; abort overrides both start and a pending handshake.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        step_nxt_s  = step_r;
        if (bus.abort) begin
            state_nxt_s = IDLE;
            idx_nxt_s   = IDX_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt_s = RUN;
                        idx_nxt_s   = IDX_ZERO;
                        step_nxt_s  = norm_step(bus.step);
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN: begin
                    if (hs_s && last_s) begin
                        state_nxt_s = DONE;
                    end else if (hs_s) begin
                        idx_nxt_s = bus.add_c;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                DONE: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = IDX_ZERO;
                end
            endcase
        end
    end

    // Every output decodes registered state only; nothing depends on smp_rdy.
    assign bus.add_a   = idx_r;
    assign bus.add_b   = step_r;
    assign bus.smp_vld = vld_s;
    assign bus.smp_idx = vld_s ? idx_r : IDX_ZERO;
    assign bus.last    = last_s;
    assign bus.busy    = (state_r == RUN) || (state_r == DONE);
    assign bus.done    = (state_r == DONE);
endmodule

// File: tb/tb_interp_sample_ctrl.sv
// Scoreboard bench: the stimulus pushes each block's expected indices, a monitor pops
// them on every handshake and checks hold stability and the done pulse.
module tb_interp_sample_ctrl;
    localparam int CNT_W = 4;
    localparam int N1    = 16;
    localparam int N2    = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    interp_sample_ctrl_if #(.CNT_W(CNT_W)) bus ();
    interp_sample_ctrl_if #(.CNT_W(CNT_W)) bus2 ();

    assign bus.add_c  = bus.add_a + bus.add_b;
    assign bus2.add_c = bus2.add_a + bus2.add_b;

    interp_sample_ctrl #(.CNT_W(CNT_W), .N_SAMPLES(N1)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    interp_sample_ctrl #(.CNT_W(CNT_W), .N_SAMPLES(N2)) u_dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2.slave)
    );

    typedef struct {
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec     = 0;
    int   n_miss    = 0;
    int   exp_done  = 0;
    int   done_seen = 0;
    int   hs_cnt    = 0;
    bit   hold_pend = 1'b0;
    int   hold_idx;
    bit   hold_last;
    bit   prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a block visits 0, s, 2s, ... below N; the final one is flagged last.
    task automatic push_block(input int s, input int n);
        int s_eff;
        s_eff = (s == 0) ? 1 : s;
        for (int v = 0; v < n; v += s_eff) begin
            exp_q.push_back('{idx: v, last: (v + s_eff >= n)});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend) begin
                check("hold_vld", bus.smp_vld, 1);
                check("hold_idx", bus.smp_idx, hold_idx);
                check("hold_last", bus.last, hold_last);
            end
            hold_pend = 1'b0;
            if (bus.smp_vld && !bus.abort) begin
                if (bus.smp_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_idx: got %0d, expected none", bus.smp_idx);
                    end else begin
                        e = exp_q.pop_front();
                        check("idx", bus.smp_idx, e.idx);
                        check("last", bus.last, e.last);
                    end
                    hs_cnt++;
                end else begin
                    hold_pend = 1'b1;
                    hold_idx  = bus.smp_idx;
                    hold_last = bus.last;
                end
            end
            if (bus.done) begin
                check("done_expected", exp_done > 0, 1);
                check("done_q_empty", exp_q.size(), 0);
                check("done_width", prev_done, 0);
                if (exp_done > 0) exp_done--;
                done_seen++;
            end
            prev_done = bus.done;
        end else begin
            hold_pend = 1'b0;
            prev_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_vld"}, bus.smp_vld, 0);
        check({name, "_busy"}, bus.busy, 0);
        check({name, "_done"}, bus.done, 0);
    endtask

    // rdy_mode: 1 = held high, 2 = toggling 1,0,..., 3 = random.
    task automatic run_block(input int s, input int rdy_mode, input bit repulse,
                             input int abort_at, input int rst_at);
        int target;
        target       = done_seen + 1;
        hs_cnt       = 0;
        bus.start    = 1'b1;
        bus.step     = 4'(s);
        bus.smp_rdy  = (rdy_mode == 1);
        push_block(s, N1);
        exp_done++;
        tick();
        bus.start = 1'b0;
        check("first_vld", bus.smp_vld, 1);
        check("first_busy", bus.busy, 1);
        for (int c = 0; c < 400; c++) begin
            if (done_seen == target) break;
            if (abort_at >= 0 && hs_cnt == abort_at) begin
                bus.abort = 1'b1;
                bus.start = 1'b0;
                tick();
                bus.abort = 1'b0;
                exp_q.delete();
                exp_done = 0;
                check_idle("abort");
                repeat (3) tick();
                check_idle("post_abort");
                return;
            end
            if (rst_at >= 0 && hs_cnt == rst_at) begin
                check("pre_rst_idx", bus.smp_idx, rst_at * ((s == 0) ? 1 : s));
                #2 rst_n = 1'b0;
                #1;
                exp_q.delete();
                exp_done = 0;
                check_idle("rst");
                check("rst_idx", bus.smp_idx, 0);
                check("rst_last", bus.last, 0);
                check("rst_add_a", bus.add_a, 0);
                check("rst_add_b", bus.add_b, 1);
                @(negedge clk);
                #1 rst_n = 1'b1;
                bus.start = 1'b0;
                repeat (3) tick();
                check_idle("post_rst");
                return;
            end
            case (rdy_mode)
                1:       bus.smp_rdy = 1'b1;
                2:       bus.smp_rdy = (c % 2 == 0);
                default: bus.smp_rdy = 1'($urandom % 2);
            endcase
            if (repulse) begin
                bus.start = 1'($urandom % 2);
                bus.step  = 4'($urandom);
            end
            tick();
        end
        check("block_done", done_seen, target);
        bus.start   = 1'b0;
        bus.smp_rdy = 1'b0;
    endtask

    initial begin
        int s;
        int cnt;
        int ab;
        bus.start   = 1'b0;
        bus.step    = 4'd0;
        bus.abort   = 1'b0;
        bus.smp_rdy = 1'b0;
        bus2.start   = 1'b0;
        bus2.step    = 4'd0;
        bus2.abort   = 1'b0;
        bus2.smp_rdy = 1'b0;

        #12;
        check_idle("reset");
        check("reset_idx", bus.smp_idx, 0);
        check("reset_last", bus.last, 0);
        check("reset_add_a", bus.add_a, 0);
        check("reset_add_b", bus.add_b, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();
        check_idle("idle");

        run_block(1, 1, 1'b0, -1, -1);
        run_block(4, 1, 1'b0, -1, -1);
        run_block(3, 2, 1'b0, -1, -1);
        run_block(0, 1, 1'b1, -1, -1);
        run_block(1, 1, 1'b0, 9, -1);
        run_block(1, 1, 1'b0, -1, -1);

        // start together with abort in IDLE must not launch a block
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.step  = 4'd5;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_idle("start_abort");
        tick();

        run_block(1, 1, 1'b0, -1, 5);

        for (int b = 0; b < 25; b++) begin
            s   = $urandom % 16;
            cnt = (N1 + ((s == 0) ? 1 : s) - 1) / ((s == 0) ? 1 : s);
            ab  = ($urandom % 4 == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
            run_block(s, 3, 1'b1, ab, -1);
            repeat ($urandom % 3) tick();
        end

        // smaller block on the second instance: N=10, stride 4 -> 0,4,8
        bus2.start   = 1'b1;
        bus2.step    = 4'd4;
        bus2.smp_rdy = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int v = 0; v < N2; v += 4) begin
            @(negedge clk);
            check("n10_vld", bus2.smp_vld, 1);
            check("n10_idx", bus2.smp_idx, v);
            check("n10_last", bus2.last, (v + 4 >= N2));
        end
        @(negedge clk);
        check("n10_done", bus2.done, 1);
        check("n10_vld_off", bus2.smp_vld, 0);
        @(negedge clk);
        check("n10_done_off", bus2.done, 0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
